// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - data-memory store monitor issuing PASS/FAIL/timeout verdicts
//
// Watches the core's store port and reaches a sticky verdict:
//   PASS  : the terminating store (pass_addr, pass_data) was seen
//   FAIL  : a store hit a non-tolerated address, the pass address got the
//           wrong value, or the run exceeded TIMEOUT_CYC cycles
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   memwrite          store strobe from the core
//   dataadr           store address
//   writedata         store data
//   pass_addr         address of the terminating store (quasi-static)
//   pass_data         value expected at pass_addr
//   ign_addr, ign_en  tolerated scratch addresses, slot i at [i*ADDR_W +: ADDR_W]
//   done, pass, fail  sticky verdict flags (done = pass | fail)
//   fail_code         0 none, 1 unexpected address, 2 data mismatch, 3 timeout
//   fail_addr         store address captured on a failing store
//   fail_data         store data captured on a failing store
//   stop_pulse        one-cycle pulse on entry to PASS or FAIL
//   cycle_count       cycles spent running, saturating
//   write_count       tolerated stores accepted, saturating

module mem_write_checker #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int N_IGN       = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memwrite,
    input  logic [ADDR_W-1:0]       dataadr,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [ADDR_W-1:0]       pass_addr,
    input  logic [DATA_W-1:0]       pass_data,
    input  logic [N_IGN*ADDR_W-1:0] ign_addr,
    input  logic [N_IGN-1:0]        ign_en,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic [1:0]              fail_code,
    output logic [ADDR_W-1:0]       fail_addr,
    output logic [DATA_W-1:0]       fail_data,
    output logic                    stop_pulse,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        write_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ADDR    = 2'd1;
    localparam logic [1:0] CODE_DATA    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Cycle count value on the edge that times out. Compared at 64 bits so a
    // TIMEOUT_CYC beyond the counter range simply never fires.
    localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [1:0]          code_q, code_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                stop_q, stop_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0]    wr_q, wr_d;

    logic                pass_hit;
    logic                data_ok;
    logic                ign_hit;
    logic                timeout_hit;

    assign pass_hit = (dataadr == pass_addr);
    assign data_ok  = (writedata == pass_data);

    always_comb begin
        ign_hit = 1'b0;
        for (int i = 0; i < N_IGN; i++) begin
            if (ign_en[i] && (dataadr == ign_addr[i*ADDR_W +: ADDR_W])) begin
                ign_hit = 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT_CYC == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (64'(cyc_q) == TO_LAST);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        stop_d  = 1'b0;
        cyc_d   = cyc_q;
        wr_d    = wr_q;

        if (state_q == S_RUN) begin
            cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 1'b1;

            // A store on the timeout edge is judged on its own merits.
            if (memwrite) begin
                if (pass_hit) begin
                    stop_d = 1'b1;
                    if (data_ok) begin
                        state_d = S_PASS;
                    end else begin
                        // Wrong value at the pass address fails even when
                        // that address is also in an ignore slot.
                        state_d = S_FAIL;
                        code_d  = CODE_DATA;
                        faddr_d = dataadr;
                        fdata_d = writedata;
                    end
                end else if (ign_hit) begin
                    wr_d = (wr_q == CNT_MAX) ? wr_q : wr_q + 1'b1;
                end else begin
                    state_d = S_FAIL;
                    code_d  = CODE_ADDR;
                    faddr_d = dataadr;
                    fdata_d = writedata;
                    stop_d  = 1'b1;
                end
            end else if (timeout_hit) begin
                state_d = S_FAIL;
                code_d  = CODE_TIMEOUT;
                stop_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            code_q  <= CODE_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
            stop_q  <= 1'b0;
            cyc_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            stop_q  <= stop_d;
            cyc_q   <= cyc_d;
            wr_q    <= wr_d;
        end
    end

    // Verdict flags decode straight from the state register, so pass and
    // fail can never both be set.
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign done        = (state_q != S_RUN);
    assign fail_code   = code_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign stop_pulse  = stop_q;
    assign cycle_count = cyc_q;
    assign write_count = wr_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - directed bench with reference model for mem_write_checker

module tb_mem_write_checker;

    logic               clk = 1'b0;
    logic               reset;
    logic               memwrite;
    logic [63:0]        dataadr;
    logic [63:0]        writedata;
    logic [63:0]        pass_addr;
    logic [63:0]        pass_data;
    logic [127:0]       ign_addr;
    logic [1:0]         ign_en;

    // instance A: TIMEOUT_CYC=10, CNT_W=16
    logic               a_done, a_pass, a_fail, a_stop;
    logic [1:0]         a_code;
    logic [63:0]        a_faddr, a_fdata;
    logic [15:0]        a_cyc, a_wr;
    // instance B: timeout disabled, CNT_W=4
    logic               b_done, b_pass, b_fail, b_stop;
    logic [1:0]         b_code;
    logic [63:0]        b_faddr, b_fdata;
    logic [3:0]         b_cyc, b_wr;

    int n_total = 0;
    int n_pass  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    mem_write_checker #(.DATA_W(64), .ADDR_W(64), .N_IGN(2), .TIMEOUT_CYC(10), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pass_addr(pass_addr), .pass_data(pass_data),
        .ign_addr(ign_addr), .ign_en(ign_en), .done(a_done), .pass(a_pass),
        .fail(a_fail), .fail_code(a_code), .fail_addr(a_faddr), .fail_data(a_fdata),
        .stop_pulse(a_stop), .cycle_count(a_cyc), .write_count(a_wr)
    );

    mem_write_checker #(.DATA_W(64), .ADDR_W(64), .N_IGN(2), .TIMEOUT_CYC(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pass_addr(pass_addr), .pass_data(pass_data),
        .ign_addr(ign_addr), .ign_en(ign_en), .done(b_done), .pass(b_pass),
        .fail(b_fail), .fail_code(b_code), .fail_addr(b_faddr), .fail_data(b_fdata),
        .stop_pulse(b_stop), .cycle_count(b_cyc), .write_count(b_wr)
    );

    // Reference model: one verdict record per instance, advanced once per edge.
    int                m_verdict [2];   // 0 running, 1 passed, 2 failed
    int                m_code    [2];
    longint unsigned   m_faddr   [2];
    longint unsigned   m_fdata   [2];
    int                m_stop    [2];
    longint unsigned   m_cyc     [2];
    longint unsigned   m_wr      [2];
    longint unsigned   m_limit   [2] = '{10, 0};
    longint unsigned   m_max     [2] = '{65535, 15};

    function automatic bit tolerated(input longint unsigned a);
        for (int s = 0; s < 2; s++) begin
            if (ign_en[s] && ign_addr[s*64 +: 64] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_edge(input int k);
        longint unsigned ran;
        m_stop[k] = 0;
        if (reset) begin
            m_verdict[k] = 0; m_code[k] = 0; m_faddr[k] = 0; m_fdata[k] = 0;
            m_cyc[k] = 0; m_wr[k] = 0;
            return;
        end
        if (m_verdict[k] != 0) return;
        ran = m_cyc[k];
        m_cyc[k] = (ran + 1 > m_max[k]) ? m_max[k] : ran + 1;
        if (memwrite) begin
            if (dataadr == pass_addr && writedata == pass_data) begin
                m_verdict[k] = 1; m_stop[k] = 1;
            end else if (dataadr == pass_addr) begin
                m_verdict[k] = 2; m_code[k] = 2; m_stop[k] = 1;
                m_faddr[k] = dataadr; m_fdata[k] = writedata;
            end else if (tolerated(dataadr)) begin
                m_wr[k] = (m_wr[k] + 1 > m_max[k]) ? m_max[k] : m_wr[k] + 1;
            end else begin
                m_verdict[k] = 2; m_code[k] = 1; m_stop[k] = 1;
                m_faddr[k] = dataadr; m_fdata[k] = writedata;
            end
        end else if (m_limit[k] != 0 && ran + 1 == m_limit[k]) begin
            m_verdict[k] = 2; m_code[k] = 3; m_stop[k] = 1;
        end
    endfunction

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    task automatic cmp(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic check_inst(input int k, input string tag,
                              input logic dn, input logic ps, input logic fl, input logic [1:0] cd,
                              input logic [63:0] fa, input logic [63:0] fd, input logic st,
                              input longint unsigned cy, input longint unsigned wr);
        cmp({tag, ".done"},        64'(dn), 64'(m_verdict[k] != 0));
        cmp({tag, ".pass"},        64'(ps), 64'(m_verdict[k] == 1));
        cmp({tag, ".fail"},        64'(fl), 64'(m_verdict[k] == 2));
        cmp({tag, ".fail_code"},   64'(cd), 64'(m_code[k]));
        cmp({tag, ".fail_addr"},   fa, m_faddr[k]);
        cmp({tag, ".fail_data"},   fd, m_fdata[k]);
        cmp({tag, ".stop_pulse"},  64'(st), 64'(m_stop[k]));
        cmp({tag, ".cycle_count"}, cy, m_cyc[k]);
        cmp({tag, ".write_count"}, wr, m_wr[k]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_inst(0, "a", a_done, a_pass, a_fail, a_code, a_faddr, a_fdata, a_stop, 64'(a_cyc), 64'(a_wr));
            check_inst(1, "b", b_done, b_pass, b_fail, b_code, b_faddr, b_fdata, b_stop, 64'(b_cyc), 64'(b_wr));
        end
    end

    // Apply one clock edge with the given inputs; returns 2 time units after it.
    task automatic step(input bit rst, input bit mw, input longint unsigned a, input longint unsigned d);
        reset = rst; memwrite = mw; dataadr = a; writedata = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        pass_addr = 64'd20; pass_data = 64'd1000;
        ign_addr = {64'd84, 64'd80};
        ign_en = 2'b01;

        // Scenario 1: pass run
        step(1, 0, 0, 0);
        started = 1'b1;
        step(1, 0, 0, 0);
        idle(2);
        step(0, 1, 80, 7);
        idle(1);
        step(0, 1, 80, 9);
        idle(2);
        step(0, 1, 20, 1000);
        cmp("s1.pass", 64'(a_pass), 1);
        cmp("s1.done", 64'(a_done), 1);
        cmp("s1.fail_code", 64'(a_code), 0);
        cmp("s1.write_count", 64'(a_wr), 2);
        cmp("s1.cycle_count", 64'(a_cyc), 8);
        cmp("s1.stop_on", 64'(a_stop), 1);
        step(0, 1, 84, 1);
        cmp("s1.stop_off", 64'(a_stop), 0);
        cmp("s1.sticky_pass", 64'(a_pass), 1);
        cmp("s1.cycle_frozen", 64'(a_cyc), 8);

        // Scenario 2: data mismatch at pass address
        step(1, 0, 0, 0);
        step(0, 1, 20, 999);
        step(0, 1, 20, 1000);
        cmp("s2.fail", 64'(a_fail), 1);
        cmp("s2.pass", 64'(a_pass), 0);
        cmp("s2.fail_code", 64'(a_code), 2);
        cmp("s2.fail_addr", a_faddr, 20);
        cmp("s2.fail_data", a_fdata, 999);

        // Scenario 3: unexpected address (slot1=84 present but disabled)
        step(1, 0, 0, 0);
        step(0, 1, 84, 5);
        cmp("s3.fail_code", 64'(a_code), 1);
        cmp("s3.fail_addr", a_faddr, 84);
        cmp("s3.fail_data", a_fdata, 5);

        // Scenario 4: timeout, then store on the timeout edge
        step(1, 0, 0, 0);
        idle(9);
        cmp("s4.not_yet", 64'(a_done), 0);
        idle(1);
        cmp("s4.fail_code", 64'(a_code), 3);
        cmp("s4.cycle_count", 64'(a_cyc), 10);
        cmp("s4.fail_addr", a_faddr, 0);
        cmp("s4.b_running", 64'(b_done), 0);
        step(1, 0, 0, 0);
        idle(9);
        step(0, 1, 20, 1000);
        cmp("s4.store_wins", 64'(a_pass), 1);
        cmp("s4.code_none", 64'(a_code), 0);

        // Scenario 5: reset after FAIL, memwrite during reset ignored
        step(1, 0, 0, 0);
        step(0, 1, 84, 5);
        cmp("s5.failed", 64'(a_code), 1);
        step(1, 1, 84, 5);
        cmp("s5.rst_fail", 64'(a_fail), 0);
        cmp("s5.rst_done", 64'(a_done), 0);
        cmp("s5.rst_code", 64'(a_code), 0);
        cmp("s5.rst_addr", a_faddr, 0);
        cmp("s5.rst_cyc", 64'(a_cyc), 0);
        step(0, 1, 20, 1000);
        cmp("s5.pass", 64'(a_pass), 1);
        cmp("s5.cyc", 64'(a_cyc), 1);

        // Scenario 6: saturation on the narrow-counter instance
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 80, 64'(i));
        cmp("s6.b_write_count", 64'(b_wr), 15);
        cmp("s6.b_cycle_count", 64'(b_cyc), 15);
        cmp("s6.b_done", 64'(b_done), 0);
        cmp("s6.a_write_count", 64'(a_wr), 20);

        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

endmodule
